gf_minv: RTL and testbench
==========================

Name: gf_minv

Overview:
- Sequential GF(2^8) exponentiation engine. Computes out15 = s0 · a^d in GF(2^8), reduced modulo x^8 + p, where p holds the low 8 bits of the field polynomial and x^8 is implicit.
- With d=8'hFE, s0=8'h01, p=8'h1B it returns the AES-field multiplicative inverse of a (a^254), with 0 mapping to 0.
- Sits as a reusable arithmetic leaf, e.g. the front end of an S-box or GF-division datapath.

Parameters:
- None. Field width is fixed at 8 bits.

Ports:
- clk    in   1  rising-edge clock
- rst    in   1  synchronous, active-high reset
- start  in   1  1-cycle request; latches a, d, p, s0
- a      in   8  base operand
- d      in   8  exponent (8'hFE = inverse)
- p      in   8  reduction polynomial low byte (8'h1B = AES)
- s0     in   8  initial accumulator/scale (8'h01 for plain power)
- busy   out  1  high while an operation is in progress
- done   out  1  1-cycle pulse when out15 is updated
- out15  out  8  result s0·a^d; held until the next done

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (rst=1 at a rising edge):
  - busy=0, done=0, out15=8'h00.
  - Internal registers base, acc, exponent shift register and bit counter are cleared.
  - rst has priority over start.
  - Reset mid-operation aborts the operation: no done pulse is produced and out15 reads 0.
- States:
  - IDLE: start=1 latches base=a, acc=s0, e=d, poly=p, cnt=0, then go to RUN with busy=1.
  - RUN, one exponent bit per cycle, LSB first:
    - if e[0]=1: acc <= gf_mul(acc, base), otherwise acc holds.
    - base <= gf_mul(base, base).
    - e <= e>>1; cnt <= cnt+1.
  - After the 8th RUN cycle (cnt=7): out15 <= final acc, done=1 for one cycle, busy=0, return to IDLE.
- Latency:
  - start sampled at edge N; done=1 and out15 valid after edge N+9.
  - Strictly 8 RUN cycles, independent of operand values; no early exit.
- start while busy=1 is ignored. Input changes during RUN have no effect, because operands were latched at start.
- start in the same cycle as done (back in IDLE) is accepted normally.
- gf_mul(x, y), combinational:
  - Carry-less shift-and-add over 8 iterations.
  - Each time the partial product shifts left and bit 7 was set, XOR with poly.
  - Result is always 8 bits.
  - Two instances are required (multiply and square); no DSP multipliers.
- Boundaries:
  - a=0, d≠0 → 0.
  - d=0 → s0.
  - a=0, d=0 → s0, since 0^0=1.
  - s0=0 → 0.
  - p is used as given; a non-irreducible p is not checked and produces the arithmetic result anyway.
- out15 changes only on done or rst.

Test Plan:
- Reset, then 10 idle cycles → busy=0, done=0, out15=8'h00. start held during rst → ignored.
- p=8'h1B, s0=8'h01, d=8'hFE, a=8'h57 → done exactly 9 edges after start, out15=8'hBF. Repeat with a=8'h53 → 8'hCA; a=8'h02 → 8'h8D; a=8'h03 → 8'hF6; a=8'h01 → 8'h01; a=8'h00 → 8'h00.
- p=8'h1B, d=8'h01, s0=8'h83, a=8'h57 → out15=8'hC1 (plain multiply). d=8'h00, s0=8'hA5 → out15=8'hA5.
- Back-to-back operations:
  - Issue start with a=8'h57, then change a to 8'hD7 and pulse start again mid-RUN → result 8'hBF only, with one done.
  - Then start on the done cycle with a=8'h53 → second done 9 edges later with 8'hCA.
- Assert rst at RUN cycle 4 → no done pulse, out15=8'h00, busy=0. The next start completes correctly.
- Randomised: 1000 random a, d, s0 with p=8'h1B, checked against a software GF model. For every a≠0, also check that gf_mul(a, out15)=8'h01 when d=8'hFE and s0=8'h01.

Source files
------------

// File: rtl/gf_minv.sv
// Sequential GF(2^8) exponentiation: out15 = s0 * a^d mod (x^8 + p).
// Square-and-multiply, one exponent bit per cycle LSB first, fixed 8-cycle run.

module gf_mul8 (
  input  logic [7:0] x,
  input  logic [7:0] y,
  input  logic [7:0] poly,
  output logic [7:0] z
);
  logic [7:0] pp;

  // Carry-less shift-and-add; each left shift that drops bit 7 folds in poly.
  always_comb begin
    z  = 8'h00;
    pp = x;
    for (int i = 0; i < 8; i++) begin
      if (y[i]) z = z ^ pp;
      pp = {pp[6:0], 1'b0} ^ (pp[7] ? poly : 8'h00);
    end
  end
endmodule

module gf_minv (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] d,
  input  logic [7:0] p,
  input  logic [7:0] s0,
  output logic       busy,
  output logic       done,
  output logic [7:0] out15
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t     state, state_nxt;
  logic [7:0] base, acc, e, poly;
  logic [2:0] cnt;
  logic [7:0] mul_z, sq_z;

  gf_mul8 u_mul (.x(acc),  .y(base), .poly(poly), .z(mul_z));
  gf_mul8 u_sq  (.x(base), .y(base), .poly(poly), .z(sq_z));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == 3'd7) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      base  <= 8'h00;
      acc   <= 8'h00;
      e     <= 8'h00;
      poly  <= 8'h00;
      cnt   <= 3'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      out15 <= 8'h00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          base <= a;
          acc  <= s0;
          e    <= d;
          poly <= p;
          cnt  <= 3'd0;
          busy <= 1'b1;
        end
        RUN: begin
          if (e[0]) acc <= mul_z;
          base <= sq_z;
          e    <= e >> 1;
          cnt  <= cnt + 3'd1;
        end
        // acc holds the final product here; publish it and drop busy.
        FIN: begin
          out15 <= acc;
          done  <= 1'b1;
          busy  <= 1'b0;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_gf_minv.sv
// Directed and randomized checks for gf_minv against a repeated-multiply GF model.

module tb_gf_minv;
  logic       clk = 1'b0;
  logic       rst, start;
  logic [7:0] a, d, p, s0;
  logic       busy, done;
  logic [7:0] out15;

  int passed = 0;
  int total  = 0;

  gf_minv dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .d(d), .p(p), .s0(s0),
    .busy(busy), .done(done), .out15(out15)
  );

  always #5 clk = ~clk;

  // Model: multiplication via polynomial long form, power via d repeated multiplies.
  function automatic logic [7:0] m_mul(input logic [7:0] x, input logic [7:0] y,
                                       input logic [7:0] pl);
    logic [15:0] prod;
    prod = 16'h0;
    for (int i = 0; i < 8; i++)
      if (y[i]) prod = prod ^ (16'(x) << i);
    for (int k = 15; k >= 8; k--)
      if (prod[k]) prod = prod ^ ((16'h0100 | 16'(pl)) << (k - 8));
    return prod[7:0];
  endfunction

  function automatic logic [7:0] m_pow(input logic [7:0] x, input logic [7:0] e,
                                       input logic [7:0] sc, input logic [7:0] pl);
    logic [7:0] r;
    r = sc;
    for (int i = 0; i < int'(e); i++) r = m_mul(r, x, pl);
    return r;
  endfunction

  // Launch one op; returns result and number of edges from start sample to done.
  task automatic do_op(input logic [7:0] ia, input logic [7:0] id, input logic [7:0] ip,
                       input logic [7:0] is0, output logic [7:0] res, output int lat);
    @(negedge clk);
    a = ia; d = id; p = ip; s0 = is0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    res = 8'hxx;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; res = out15; break; end
    end
  endtask

  task automatic chk8(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else passed++;
  endtask

  task automatic test_reset;
    int dn;
    rst = 1'b1; start = 1'b1; a = 8'h57; d = 8'hFE; p = 8'h1B; s0 = 8'h01;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0; start = 1'b0;
    dn = 0;
    repeat (10) begin @(posedge clk); #1; if (done) dn++; end
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b expected 0", done); else passed++;
    total++; if (out15 !== 8'h00) $display("FAIL reset_out15: got %h expected 00", out15); else passed++;
    total++; if (dn != 0) $display("FAIL reset_no_done: got %0d done pulses expected 0", dn); else passed++;
  endtask

  task automatic test_inverse;
    logic [7:0] va [6] = '{8'h57, 8'h53, 8'h02, 8'h03, 8'h01, 8'h00};
    logic [7:0] vr [6] = '{8'hBF, 8'hCA, 8'h8D, 8'hF6, 8'h01, 8'h00};
    logic [7:0] r;
    int lat;
    for (int i = 0; i < 6; i++) begin
      do_op(va[i], 8'hFE, 8'h1B, 8'h01, r, lat);
      total++;
      if (lat != 9) $display("FAIL inv_latency a=%h: got %0d edges expected 9", va[i], lat);
      else passed++;
      total++;
      if (r !== vr[i]) $display("FAIL inv a=%h: got %h expected %h", va[i], r, vr[i]);
      else passed++;
    end
    @(posedge clk); #1;
    total++; if (done !== 1'b0) $display("FAIL done_pulse_width: got %b expected 0", done); else passed++;
    total++; if (out15 !== 8'h00) $display("FAIL out15_hold: got %h expected 00", out15); else passed++;
  endtask

  task automatic test_boundaries;
    logic [7:0] r;
    int lat;
    do_op(8'h57, 8'h01, 8'h1B, 8'h83, r, lat); chk8("mul_57x83", r, 8'hC1);
    do_op(8'h57, 8'h00, 8'h1B, 8'hA5, r, lat); chk8("d0_s0", r, 8'hA5);
    do_op(8'h00, 8'h00, 8'h1B, 8'h3C, r, lat); chk8("a0_d0", r, 8'h3C);
    do_op(8'h00, 8'h05, 8'h1B, 8'h3C, r, lat); chk8("a0_dnz", r, 8'h00);
    do_op(8'h57, 8'hFE, 8'h1B, 8'h00, r, lat); chk8("s0_zero", r, 8'h00);
    do_op(8'h02, 8'h08, 8'h1B, 8'h01, r, lat); chk8("x8_mod", r, 8'h1B);
    do_op(8'h02, 8'h08, 8'h00, 8'h01, r, lat); chk8("x8_p00", r, 8'h00);
  endtask

  task automatic test_back_to_back;
    int dn, first;
    logic [7:0] r, r2;
    int lat;
    @(negedge clk);
    a = 8'h57; d = 8'hFE; p = 8'h1B; s0 = 8'h01; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    dn = 0; first = 0; r = 8'h00;
    for (int i = 1; i <= 9; i++) begin
      if (i == 3) begin @(negedge clk); a = 8'hD7; start = 1'b1; end
      @(posedge clk); #1;
      if (i == 3) start = 1'b0;
      if (done) begin dn++; if (first == 0) begin first = i; r = out15; end end
    end
    total++; if (first != 9) $display("FAIL b2b_latency: got %0d edges expected 9", first); else passed++;
    chk8("b2b_result", r, 8'hBF);
    total++; if (dn != 1) $display("FAIL b2b_done_count: got %0d expected 1", dn); else passed++;
    do_op(8'h53, 8'hFE, 8'h1B, 8'h01, r2, lat);
    total++; if (lat != 9) $display("FAIL b2b_second_latency: got %0d expected 9", lat); else passed++;
    chk8("b2b_second", r2, 8'hCA);
  endtask

  task automatic test_abort;
    int dn;
    logic [7:0] r;
    int lat;
    @(negedge clk);
    a = 8'h57; d = 8'hFE; p = 8'h1B; s0 = 8'h01; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    total++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else passed++;
    chk8("abort_out15", out15, 8'h00);
    dn = 0;
    repeat (12) begin @(posedge clk); #1; if (done) dn++; end
    total++; if (dn != 0) $display("FAIL abort_no_done: got %0d expected 0", dn); else passed++;
    do_op(8'h02, 8'hFE, 8'h1B, 8'h01, r, lat);
    chk8("abort_recover", r, 8'h8D);
  endtask

  task automatic test_random;
    logic [7:0] ra, rd, rs, r, exp;
    int lat;
    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom); rd = 8'($urandom); rs = 8'($urandom);
      if (i % 4 == 0) begin rd = 8'hFE; rs = 8'h01; end
      exp = m_pow(ra, rd, rs, 8'h1B);
      do_op(ra, rd, 8'h1B, rs, r, lat);
      total++;
      if (r !== exp || lat != 9)
        $display("FAIL rand a=%h d=%h s0=%h: got %h lat %0d expected %h lat 9", ra, rd, rs, r, lat, exp);
      else passed++;
      if (rd == 8'hFE && rs == 8'h01 && ra != 8'h00) begin
        total++;
        if (m_mul(ra, r, 8'h1B) !== 8'h01)
          $display("FAIL rand_inv_prop a=%h: got a*out15=%h expected 01", ra, m_mul(ra, r, 8'h1B));
        else passed++;
      end
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'h00; d = 8'h00; p = 8'h00; s0 = 8'h00;
    test_reset();
    test_inverse();
    test_boundaries();
    test_back_to_back();
    test_abort();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
